// File: rtl/axil_crossbar_sm_rd.sv
// Read-channel controller for one master port of the AXI-Lite interconnect:
// single outstanding AR, slave decode from address bits, local DECERR for unmapped slots.
module axil_crossbar_sm_rd #(
  parameter int NUMBER_SLAVE   = 8,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int SLAVE_SEL_LSB  = 28
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] m_axil_araddr,
  input  logic                      m_axil_arvalid,
  output logic                      m_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0] m_axil_rdata,
  output logic [1:0]                m_axil_rresp,
  output logic                      m_axil_rvalid,
  input  logic                      m_axil_rready,
  output logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
  output logic [NUMBER_SLAVE-1:0]   s_axil_arvalid,
  input  logic [NUMBER_SLAVE-1:0]   s_axil_arready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axil_rdata [NUMBER_SLAVE],
  input  logic [1:0]                s_axil_rresp [NUMBER_SLAVE],
  input  logic [NUMBER_SLAVE-1:0]   s_axil_rvalid,
  output logic [NUMBER_SLAVE-1:0]   s_axil_rready,
  output logic [NUMBER_SLAVE-1:0]   grant_rd_trans
);

  localparam int SEL_W = (NUMBER_SLAVE > 1) ? $clog2(NUMBER_SLAVE) : 1;
  localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W+1)'(NUMBER_SLAVE);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and our ready outputs depend only on registered state.
  typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_RESP} state_t;

  state_t                    state, state_next;
  logic [SEL_W-1:0]          sel_q;
  logic [SEL_W-1:0]          sel_in;
  logic                      sel_ok;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                rresp_q;
  logic                      ar_hs;
  logic [NUMBER_SLAVE-1:0]   sel_oh;
  logic                      slv_arready;
  logic                      slv_rvalid;
  logic [AXI_DATA_WIDTH-1:0] slv_rdata;
  logic [1:0]                slv_rresp;

  assign sel_in = m_axil_araddr[SLAVE_SEL_LSB +: SEL_W];
  assign sel_ok = ({1'b0, sel_in} < SEL_LIMIT);
  assign ar_hs  = m_axil_arready & m_axil_arvalid;

  // Only the selected slave is ever looked at; everything else is ignored.
  always_comb begin
    sel_oh      = '0;
    slv_arready = 1'b0;
    slv_rvalid  = 1'b0;
    slv_rdata   = '0;
    slv_rresp   = '0;
    for (int i = 0; i < NUMBER_SLAVE; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_oh[i]   = 1'b1;
        slv_arready = s_axil_arready[i];
        slv_rvalid  = s_axil_rvalid[i];
        slv_rdata   = s_axil_rdata[i];
        slv_rresp   = s_axil_rresp[i];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (ar_hs) state_next = sel_ok ? ST_AR : ST_RESP;
      ST_AR:   if (slv_arready) state_next = ST_R;
      ST_R:    if (slv_rvalid) state_next = ST_RESP;
      ST_RESP: if (m_axil_rready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= ST_IDLE;
      m_axil_arready <= 1'b0;
      sel_q          <= '0;
      addr_q         <= '0;
      rdata_q        <= '0;
      rresp_q        <= '0;
    end else begin
      state          <= state_next;
      m_axil_arready <= (state_next == ST_IDLE);
      if (state == ST_IDLE && ar_hs) begin
        addr_q <= m_axil_araddr;
        if (sel_ok) begin
          sel_q <= sel_in;
        end else begin
          rdata_q <= '0;
          rresp_q <= 2'b11;
        end
      end
      if (state == ST_R && slv_rvalid) begin
        rdata_q <= slv_rdata;
        rresp_q <= slv_rresp;
      end
    end
  end

  assign s_axil_araddr  = addr_q;
  assign s_axil_arvalid = (state == ST_AR) ? sel_oh : '0;
  assign s_axil_rready  = (state == ST_R) ? sel_oh : '0;
  assign grant_rd_trans = (state == ST_AR || state == ST_R) ? sel_oh : '0;
  assign m_axil_rvalid  = (state == ST_RESP);
  assign m_axil_rdata   = rdata_q;
  assign m_axil_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_crossbar_sm_rd.sv
// Randomised scoreboard bench for axil_crossbar_sm_rd with six slaves (sel 6 and 7 unmapped).
module tb_axil_crossbar_sm_rd;

  localparam int NS = 6;

  logic        aclk;
  logic        aresetn;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_rready;
  logic [NS-1:0] s_arready;
  logic [NS-1:0] s_rvalid;
  logic [31:0] s_rdata [NS];
  logic [1:0]  s_rresp [NS];

  logic          m_axil_arready;
  logic [31:0]   m_axil_rdata;
  logic [1:0]    m_axil_rresp;
  logic          m_axil_rvalid;
  logic [31:0]   s_axil_araddr;
  logic [NS-1:0] s_axil_arvalid;
  logic [NS-1:0] s_axil_rready;
  logic [NS-1:0] grant_rd_trans;

  axil_crossbar_sm_rd #(
    .NUMBER_SLAVE(NS), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .SLAVE_SEL_LSB(28)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_axil_araddr(m_araddr), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_rready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_arready),
    .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp), .s_axil_rvalid(s_rvalid),
    .s_axil_rready(s_axil_rready), .grant_rd_trans(grant_rd_trans)
  );

  // ---------------- clock / reset ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;
  logic [33:0] exp_q[$];
  int ar_cyc_q[$];
  int ar_wait [NS];
  int r_wait [NS];
  logic [NS-1:0] stray_on;
  int hold_cnt;
  logic rr_rand;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: the slave select field is address bits [30:28]; slots >= NS are DECERR.
  function automatic int sel_of(input logic [31:0] addr);
    return int'((addr >> 28) & 32'd7);
  endfunction

  function automatic logic [33:0] model(input logic [31:0] addr);
    int s;
    s = sel_of(addr);
    if (s >= NS) return {2'b11, 32'h0};
    return {s_rresp[s], s_rdata[s]};
  endfunction

  // ---------------- slave models ----------------
  logic [NS-1:0] rv, pend, ar_hs_s, r_hs_s;
  int ar_cnt [NS];
  int r_cnt [NS];

  initial begin
    s_arready = '0; s_rvalid = '0; rv = '0; pend = '0; stray_on = '0;
    for (int i = 0; i < NS; i++) begin
      ar_cnt[i] = 0; r_cnt[i] = 0; ar_wait[i] = 0; r_wait[i] = 0;
      s_rdata[i] = '0; s_rresp[i] = '0;
    end
    forever begin
      @(negedge aclk);
      ar_hs_s = s_axil_arvalid & s_arready;
      r_hs_s  = s_axil_rready & s_rvalid;
      @(posedge aclk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (!aresetn) begin
          pend[i] = 1'b0; rv[i] = 1'b0; ar_cnt[i] = 0; r_cnt[i] = 0; s_arready[i] = 1'b0;
        end else begin
          if (r_hs_s[i]) begin rv[i] = 1'b0; pend[i] = 1'b0; end
          if (ar_hs_s[i]) begin pend[i] = 1'b1; r_cnt[i] = 0; end
          if (s_axil_arvalid[i]) begin
            if (ar_cnt[i] >= ar_wait[i]) s_arready[i] = 1'b1;
            else begin s_arready[i] = 1'b0; ar_cnt[i]++; end
          end else begin
            s_arready[i] = 1'b0; ar_cnt[i] = 0;
          end
          if (pend[i] && !rv[i]) begin
            if (r_cnt[i] >= r_wait[i]) rv[i] = 1'b1;
            else r_cnt[i]++;
          end
        end
      end
      s_rvalid = rv | stray_on;
    end
  end

  // ---------------- master R ready driver ----------------
  initial begin
    m_rready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (m_axil_rvalid && hold_cnt > 0) begin
        m_rready = 1'b0;
        hold_cnt--;
      end else if (rr_rand) m_rready = 1'($urandom_range(0, 1));
      else m_rready = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0;
  logic busy = 1'b0;
  int tgt, c0, exp_lat;
  logic [31:0] cur_addr;
  logic rv_seen, prev_mr_wait, prev_sar_wait, last_r_hs;
  logic [33:0] prev_r;
  logic [NS-1:0] prev_sar, exp_oh;
  int ar_count = 0;
  int r_count = 0;
  int last_r_cyc = 0;

  initial begin
    rv_seen = 0; prev_mr_wait = 0; prev_sar_wait = 0; last_r_hs = 0;
    tgt = 0; c0 = 0; exp_lat = 0; cur_addr = '0; prev_r = '0; prev_sar = '0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        busy = 0; rv_seen = 0; prev_mr_wait = 0; prev_sar_wait = 0; last_r_hs = 0;
      end else begin
        if (last_r_hs) chk("arready_after_r", 64'(m_axil_arready), 64'd1);
        if (busy) chk("arready_while_busy", 64'(m_axil_arready), 64'd0);
        exp_oh = '0;
        if (busy && tgt < NS) exp_oh[tgt] = 1'b1;
        if (|s_axil_arvalid || |s_axil_rready) chk("grant", 64'(grant_rd_trans), 64'(exp_oh));
        if (|s_axil_arvalid) begin
          chk("s_arvalid_sel", 64'(s_axil_arvalid), 64'(exp_oh));
          chk("s_araddr", 64'(s_axil_araddr), 64'(cur_addr));
        end
        if (|s_axil_rready) chk("s_rready_sel", 64'(s_axil_rready), 64'(exp_oh));
        if (|grant_rd_trans) chk("grant_only_owned", 64'(grant_rd_trans), 64'(exp_oh));
        if (prev_mr_wait)
          chk("m_r_hold", {29'd0, m_axil_rvalid, m_axil_rresp, m_axil_rdata}, {29'd0, 1'b1, prev_r});
        if (prev_sar_wait) chk("s_ar_hold", 64'(s_axil_arvalid), 64'(prev_sar));
        if (m_axil_rvalid) begin
          chk("rvalid_when_busy", 64'(busy), 64'd1);
          if (!rv_seen) begin
            rv_seen = 1;
            chk("rvalid_latency", 64'(cyc - c0), 64'(exp_lat));
          end
        end
        if (m_axil_rvalid && m_rready) begin
          if (exp_q.size() == 0) chk("r_unexpected", 64'(m_axil_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
          else chk("rdata_rresp", {30'd0, m_axil_rresp, m_axil_rdata}, {30'd0, exp_q.pop_front()});
          r_count++;
          last_r_cyc = cyc;
          busy = 0;
          rv_seen = 0;
        end
        if (m_arvalid && m_axil_arready) begin
          chk("ar_when_idle", 64'(busy), 64'd0);
          busy = 1;
          cur_addr = m_araddr;
          tgt = sel_of(m_araddr);
          exp_lat = (tgt >= NS) ? 1 : 3 + ar_wait[tgt] + r_wait[tgt];
          c0 = cyc;
          ar_count++;
          ar_cyc_q.push_back(cyc);
        end
        prev_mr_wait  = m_axil_rvalid && !m_rready;
        prev_r        = {m_axil_rresp, m_axil_rdata};
        prev_sar_wait = (|s_axil_arvalid) && !(|(s_axil_arvalid & s_arready));
        prev_sar      = s_axil_arvalid;
        last_r_hs     = m_axil_rvalid && m_rready;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] addr);
    exp_q.push_back(model(addr));
    m_araddr  = addr;
    m_arvalid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge aclk);
      if (m_axil_arready) break;
    end
    chk("ar_accept", 64'(m_axil_arready), 64'd1);
    @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (exp_q.size() != 0 || busy); n++) @(negedge aclk);
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] addr);
    issue(addr);
    m_arvalid = 1'b0;
    drain();
  endtask

  task automatic cfg(input int s, input logic [31:0] d, input logic [1:0] r, input int aw, input int rw);
    s_rdata[s] = d; s_rresp[s] = r; ar_wait[s] = aw; r_wait[s] = rw;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctrl"}, 64'({m_axil_arready, m_axil_rvalid, m_axil_rresp,
                              s_axil_arvalid, s_axil_rready, grant_rd_trans}), 64'd0);
    chk({name, "_data"}, {m_axil_rdata, s_axil_araddr}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ar0, r0, s, t;
    logic [31:0] a;
    aresetn = 1'b0; m_arvalid = 1'b0; m_araddr = '0; hold_cnt = 0; rr_rand = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk_zero("reset");
    @(negedge aclk); #2 aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("arready_after_reset", 64'(m_axil_arready), 64'd1);

    // mapped read to slave 3, zero wait
    cfg(3, 32'hDEAD_BEEF, 2'b00, 0, 0);
    do_read(32'h3000_0010);

    // decode errors (sel 6 and 7 unmapped)
    cfg(5, 32'h5555_5555, 2'b01, 0, 0);
    do_read(32'h6000_0000);
    do_read(32'hF123_4567);

    // back-pressure on both sides, SLVERR passthrough
    cfg(1, 32'h0BAD_F00D, 2'b10, 3, 2);
    hold_cnt = 4;
    do_read(32'h1000_0004);

    // stray response from slave 4 while slave 2 is the target
    cfg(2, 32'h0000_2222, 2'b00, 0, 1);
    cfg(4, 32'h0000_1111, 2'b00, 0, 0);
    stray_on = 6'b010000;
    do_read(32'h2000_0008);
    stray_on = '0;

    // asynchronous reset while waiting in R
    cfg(2, 32'h0000_2BAD, 2'b00, 0, 8);
    issue(32'h2000_0040);
    m_arvalid = 1'b0;
    for (int n = 0; n < 20 && s_axil_rready == '0; n++) @(negedge aclk);
    chk("reach_r", 64'(s_axil_rready), 64'h04);
    @(negedge aclk); #2 aresetn = 1'b0;
    #1;
    chk_zero("mid_reset");
    exp_q.delete();
    @(posedge aclk); #1;
    chk_zero("mid_reset_held");
    @(negedge aclk); #2 aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("arready_after_release", 64'(m_axil_arready), 64'd1);
    cfg(2, 32'h0002_C0DE, 2'b01, 0, 0);
    do_read(32'h2000_0080);

    // back-to-back reads with arvalid held: slaves 0, 5, 0
    cfg(0, 32'hA0A0_0001, 2'b00, 0, 0);
    cfg(5, 32'hA5A5_0005, 2'b01, 0, 0);
    ar0 = ar_count; r0 = r_count;
    ar_cyc_q.delete();
    issue(32'h0000_0100);
    issue(32'h5000_0200);
    cfg(0, 32'hA0A0_0003, 2'b00, 0, 0);
    issue(32'h0000_0300);
    m_arvalid = 1'b0;
    drain();
    chk("b2b_ar_count", 64'(ar_count - ar0), 64'd3);
    chk("b2b_r_count", 64'(r_count - r0), 64'd3);
    chk("b2b_ar_log", 64'(ar_cyc_q.size()), 64'd3);
    if (ar_cyc_q.size() > 0) chk("b2b_cycles", 64'(last_r_cyc - ar_cyc_q[0] + 1), 64'd12);

    // randomized reads
    rr_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NS; i++)
        cfg(i, $urandom(), 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3));
      a = $urandom();
      t = sel_of(a);
      if ($urandom_range(0, 1) == 1) begin
        s = $urandom_range(0, NS - 1);
        if (s != t) stray_on[s] = 1'b1;
      end
      do_read(a);
      stray_on = '0;
    end
    rr_rand = 1'b0;

    repeat (3) @(posedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
